// File: rtl/dadda_product_accumulator_pkg.sv
// Shared types and default widths for the Dadda product accumulator.
// Optional feature macro: DADDA_ACC_SAT_EN (saturating accumulation).
package dadda_acc_pkg;

  localparam int DADDA_PROD_W = 32;
  localparam int DADDA_ACC_W  = 40;
  localparam int DADDA_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/dadda_product_accumulator_if.sv
// Product-in / frame-result-out handshake bundle for the Dadda product accumulator.
// Optional feature macro: DADDA_ACC_SAT_EN (does not change this interface).
interface dadda_product_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Upstream product source and downstream result sink.
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/dadda_product_accumulator_adder.sv
// Combinational accumulator + zero-extended product adder with carry-out.
// Optional feature macro: DADDA_ACC_SAT_EN clamps the sum to all-ones on carry;
// otherwise the sum wraps modulo 2^ACC_W.
module dadda_acc_adder #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_full;

  // Full-width sum; the extra top bit is the carry out of bit ACC_W-1.
  always_comb begin
    w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    o_carry = w_full[ACC_W];
`ifdef DADDA_ACC_SAT_EN
    // Once clamped, any further non-zero product carries again, so the
    // accumulator stays pinned at all-ones for the rest of the frame.
    if (w_full[ACC_W]) begin
      o_sum = {ACC_W{1'b1}};
    end else begin
      o_sum = w_full[ACC_W-1:0];
    end
`else
    o_sum = w_full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/dadda_product_accumulator.sv
// Streaming frame accumulator for 16x16 Dadda multiplier products.
// Sums a frame of products, then presents sum/count/overflow on a registered
// output handshake. Optional feature macro: DADDA_ACC_SAT_EN (saturate
// instead of wrap on overflow).
module dadda_product_accumulator
  import dadda_acc_pkg::*;
#(
  parameter int PROD_W = DADDA_PROD_W,
  parameter int ACC_W  = DADDA_ACC_W,
  parameter int CNT_W  = DADDA_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  dadda_product_accumulator_if.slave   bus
);

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_beat;
  logic             w_res;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_beat = bus.in_valid && r_in_ready;
  assign w_res  = r_out_valid && bus.out_ready;

  dadda_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .i_acc   (r_acc),
    .i_prod  (bus.in_prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Beat counter increment that sticks at all-ones instead of wrapping.
  always_comb begin
    if (r_cnt == {CNT_W{1'b1}}) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic for the IDLE/ACCUM/HOLD frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_beat) begin
          if (bus.in_last) begin
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      HOLD: begin
        if (w_res) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus handshake flags decoded from the next state, so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != HOLD);
      r_out_valid <= (w_state_nxt == HOLD);
    end
  end

  // Running accumulator, beat counter and sticky overflow for the open frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= {ACC_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      r_ovf <= 1'b0;
    end else if (w_res) begin
      r_acc <= {ACC_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_inc;
      r_ovf <= r_ovf | w_carry;
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
      r_ovf <= r_ovf;
    end
  end

  // Result registers: loaded only with the final beat, frozen through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_acc   <= {ACC_W{1'b0}};
      r_out_count <= {CNT_W{1'b0}};
      r_out_ovf   <= 1'b0;
    end else if (w_beat && bus.in_last) begin
      r_out_acc   <= w_sum;
      r_out_count <= w_cnt_inc;
      r_out_ovf   <= r_ovf | w_carry;
    end else begin
      r_out_acc   <= r_out_acc;
      r_out_count <= r_out_count;
      r_out_ovf   <= r_out_ovf;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Directed self-checking bench for dadda_product_accumulator.
// Instance u_dut uses default widths; u_dut2 uses ACC_W=32 / CNT_W=2 for
// overflow and counter-saturation cases. Honours DADDA_ACC_SAT_EN.
module tb_dadda_product_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dadda_product_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) bus1 ();
  dadda_product_accumulator_if #(.PROD_W(32), .ACC_W(32), .CNT_W(2))  bus2 ();

  dadda_product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  dadda_product_accumulator #(.PROD_W(32), .ACC_W(32), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input logic [31:0] prod, input logic last);
    bus1.in_valid = 1'b1;
    bus1.in_prod  = prod;
    bus1.in_last  = last;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  task automatic beat2(input logic [31:0] prod, input logic last);
    bus2.in_valid = 1'b1;
    bus2.in_prod  = prod;
    bus2.in_last  = last;
    tick();
    bus2.in_valid = 1'b0;
  endtask

  task automatic accept_result();
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    bus2.out_ready = 1'b0;
  endtask

  logic [31:0] exp_ovf_acc;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_prod = 32'h0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_prod = 32'h0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  {63'd0, bus1.in_ready},  64'd0);
    check("rst_out_valid", {63'd0, bus1.out_valid}, 64'd0);
    check("rst_out_acc",   {24'd0, bus1.out_acc},   64'd0);
    check("rst_out_count", {48'd0, bus1.out_count}, 64'd0);
    check("rst_out_ovf",   {63'd0, bus1.out_ovf},   64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {63'd0, bus1.in_ready}, 64'd1);

    // Single-beat frame
    beat1(32'h0000_FE01, 1'b1);
    check("single_valid", {63'd0, bus1.out_valid}, 64'd1);
    check("single_acc",   {24'd0, bus1.out_acc},   64'hFE01);
    check("single_count", {48'd0, bus1.out_count}, 64'd1);
    check("single_ovf",   {63'd0, bus1.out_ovf},   64'd0);
    check("single_hold_ready", {63'd0, bus1.in_ready}, 64'd0);
    accept_result();
    check("single_released_valid", {63'd0, bus1.out_valid}, 64'd0);
    check("single_released_ready", {63'd0, bus1.in_ready},  64'd1);

    // Three-beat frame
    beat1(32'h0000_A956, 1'b0);
    check("three_mid_valid", {63'd0, bus1.out_valid}, 64'd0);
    beat1(32'h0000_FE01, 1'b0);
    beat1(32'h0000_00FF, 1'b1);
    check("three_valid", {63'd0, bus1.out_valid}, 64'd1);
    check("three_acc",   {24'd0, bus1.out_acc},   64'h1A856);
    check("three_count", {48'd0, bus1.out_count}, 64'd3);
    check("three_ovf",   {63'd0, bus1.out_ovf},   64'd0);

    // Back-pressure during HOLD with upstream beats offered
    bus1.in_valid = 1'b1;
    bus1.in_prod  = 32'h0000_1234;
    bus1.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {63'd0, bus1.out_valid}, 64'd1);
      check("bp_ready", {63'd0, bus1.in_ready},  64'd0);
      check("bp_acc",   {24'd0, bus1.out_acc},   64'h1A856);
      check("bp_count", {48'd0, bus1.out_count}, 64'd3);
    end
    bus1.in_valid = 1'b0;
    accept_result();
    check("bp_release_valid", {63'd0, bus1.out_valid}, 64'd0);
    beat1(32'h0000_0005, 1'b1);
    check("bp_next_acc",   {24'd0, bus1.out_acc},   64'h5);
    check("bp_next_count", {48'd0, bus1.out_count}, 64'd1);
    accept_result();

    // Overflow on 32-bit accumulator
`ifdef DADDA_ACC_SAT_EN
    exp_ovf_acc = 32'hFFFF_FFFF;
`else
    exp_ovf_acc = 32'hFFFC_0002;
`endif
    beat2(32'hFFFE_0001, 1'b0);
    beat2(32'hFFFE_0001, 1'b1);
    check("ovf_valid", {63'd0, bus2.out_valid}, 64'd1);
    check("ovf_acc",   {32'd0, bus2.out_acc},   {32'd0, exp_ovf_acc});
    check("ovf_flag",  {63'd0, bus2.out_ovf},   64'd1);
    check("ovf_count", {62'd0, bus2.out_count}, 64'd2);
    accept_result();

    // Counter saturation (CNT_W=2) must not raise overflow
    for (int i = 0; i < 4; i++) begin
      beat2(32'h0000_0001, 1'b0);
    end
    beat2(32'h0000_0001, 1'b1);
    check("sat_cnt_acc",   {32'd0, bus2.out_acc},   64'd5);
    check("sat_cnt_count", {62'd0, bus2.out_count}, 64'd3);
    check("sat_cnt_ovf",   {63'd0, bus2.out_ovf},   64'd0);
    accept_result();
    check("sat_cnt_ovf_cleared_next", {63'd0, bus2.in_ready}, 64'd1);

    // Reset mid-frame after two beats
    beat1(32'h0000_0010, 1'b0);
    beat1(32'h0000_0020, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_acc",   {24'd0, bus1.out_acc},   64'd0);
    check("midrst_count", {48'd0, bus1.out_count}, 64'd0);
    check("midrst_valid", {63'd0, bus1.out_valid}, 64'd0);
    check("midrst_ready", {63'd0, bus1.in_ready},  64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_ready_back", {63'd0, bus1.in_ready}, 64'd1);
    beat1(32'h0000_0002, 1'b1);
    check("midrst_next_acc",   {24'd0, bus1.out_acc},   64'h2);
    check("midrst_next_count", {48'd0, bus1.out_count}, 64'd1);
    accept_result();

    // Back-to-back frames with out_ready held high
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_prod   = 32'h0000_0001;
    bus1.in_last   = 1'b0;
    tick();
    check("b2b_a1_valid", {63'd0, bus1.out_valid}, 64'd0);
    bus1.in_prod = 32'h0000_0002;
    bus1.in_last = 1'b1;
    tick();
    check("b2b_a_valid", {63'd0, bus1.out_valid}, 64'd1);
    check("b2b_a_acc",   {24'd0, bus1.out_acc},   64'h3);
    check("b2b_a_count", {48'd0, bus1.out_count}, 64'd2);
    bus1.in_prod = 32'h0000_0007;
    bus1.in_last = 1'b1;
    tick();
    check("b2b_bubble_valid", {63'd0, bus1.out_valid}, 64'd0);
    check("b2b_bubble_ready", {63'd0, bus1.in_ready},  64'd1);
    check("b2b_bubble_acc",   {24'd0, bus1.out_acc},   64'h3);
    tick();
    bus1.in_valid = 1'b0;
    check("b2b_b_valid", {63'd0, bus1.out_valid}, 64'd1);
    check("b2b_b_acc",   {24'd0, bus1.out_acc},   64'h7);
    check("b2b_b_count", {48'd0, bus1.out_count}, 64'd1);
    tick();
    bus1.out_ready = 1'b0;
    check("b2b_end_valid", {63'd0, bus1.out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dadda_product_accumulator.md
# dadda_product_accumulator

Streaming accumulator placed directly downstream of the 16x16 Dadda multiplier. It takes each unsigned 32-bit product through a valid/ready handshake and sums the products of a frame into a wide register. When the last product of a frame is accepted, it presents the frame sum, the beat count and an overflow flag on a registered output handshake. This turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- `PROD_W`, default 32: product width; matches the multiplier's `final_result`.
- `ACC_W`, default 40: accumulator width; must be ≥ `PROD_W`.
- `CNT_W`, default 16: beat-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_prod`  in  `PROD_W`  unsigned product, normally the multiplier's `final_result`.
- `in_last`  in  1  current beat ends the frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  `ACC_W`  frame sum.
- `out_count`  out  `CNT_W`  beats in the frame.
- `out_ovf`  out  1  sum exceeded `ACC_W` bits at some point in the frame.

## Operation
- Beat accept: `in_valid && in_ready`. Result accept: `out_valid && out_ready`.
- State machine has three states:
  - IDLE: accumulator and counter are 0, `in_ready`=1.
  - ACCUM: at least one beat held, `in_ready`=1.
  - HOLD: result presented, `in_ready`=0, `out_valid`=1.
- Transitions:
  - IDLE → ACCUM on an accepted beat with `in_last`=0.
  - IDLE → HOLD on an accepted beat with `in_last`=1 (single-beat frame).
  - ACCUM → HOLD on an accepted beat with `in_last`=1.
  - HOLD → IDLE on result accept; accumulator, counter and flag clear on the same edge.
- Arithmetic:
  - `acc_next = acc + zero_extend(in_prod)`, computed at `ACC_W+1` bits.
  - Carry out of bit `ACC_W-1` sets the sticky overflow bit for the frame.
- Counter increments per accepted beat and saturates at all-ones; saturating does not set `out_ovf`.
- `out_acc`, `out_count` and `out_ovf` are registered, updated only on the final beat, and stable throughout HOLD.
- `in_prod` and `in_last` are ignored when `in_valid`=0.
- `in_ready` depends only on state, never combinationally on `out_ready`.

## Timing
- Reset values: state IDLE, `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0.
- `in_ready` rises on the first clock edge after `rst` deasserts.
- Throughput: one beat per cycle in IDLE and ACCUM.
- Latency: last beat accepted at edge t → `out_valid`=1 after edge t, carrying the sum including that beat.
- Result accepted at edge t → `in_ready`=1 after edge t. There is one bubble cycle between frames: no beat is accepted in the same cycle as the result handshake.
- `out_valid` remains high indefinitely under back-pressure.
- Reset asserted mid-frame or in HOLD discards the partial or pending result immediately, asynchronously.

## Configuration
- `DADDA_ACC_SAT_EN`:
  - Defined: on overflow the accumulator clamps to all-ones and holds there for the rest of the frame; `out_ovf`=1.
  - Undefined: the accumulator wraps modulo 2^`ACC_W`; `out_ovf`=1 still reports the wrap.

## Structure
- Package `dadda_acc_pkg` holds:
  - state enum `acc_state_t` {IDLE, ACCUM, HOLD};
  - default width constants `DADDA_PROD_W`=32, `DADDA_ACC_W`=40, `DADDA_CNT_W`=16.
- One sub-module, `dadda_acc_adder`: combinational `ACC_W`+`PROD_W` adder with carry-out and the macro-selected wrap/saturate result.
- FSM, counter, sticky flag and output registers live in the top module.

## Test plan
- Single-beat frame: `in_prod`=0xFE01 with `in_last`=1 → after one cycle `out_acc`=0xFE01, `out_count`=1, `out_ovf`=0.
- Three-beat frame: 0xA956, 0xFE01, 0x00FF (last) → `out_acc`=0x1A856, `out_count`=3.
- Back-pressure: `out_ready`=0 for 5 cycles during HOLD → `out_valid` held, `in_ready`=0, outputs unchanged; upstream beats offered during HOLD are not consumed.
- Overflow with `ACC_W`=32, two beats of 0xFFFE0001:
  - without the macro → `out_acc`=0xFFFC0002, `out_ovf`=1;
  - with `DADDA_ACC_SAT_EN` → `out_acc`=0xFFFFFFFF, `out_ovf`=1.
- Reset mid-frame after 2 beats → all outputs 0 immediately; the next frame 0x0002 (last) → `out_acc`=0x2, `out_count`=1.
- Back-to-back frames with `out_ready`=1 → exactly one bubble cycle between frames; each frame's sum is independent.
